// File: rtl/mem_fill_arbiter_if.sv
// Bus bundle between the two cache fill FSMs, the fill arbiter and main memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_fill_arbiter_if #(
  parameter int WORDS = 8
);
  localparam int CW = $clog2(WORDS);

  logic          i_req;
  logic [15:0]   i_addr;
  logic          d_req;
  logic [15:0]   d_addr;
  logic [15:0]   memory_data;
  logic          memory_data_valid;
  logic          mem_en;
  logic [15:0]   memory_address;
  logic          i_grant;
  logic          d_grant;
  logic          i_data_valid;
  logic          d_data_valid;
  logic [15:0]   fill_data;
  logic [CW-1:0] fill_word;
  logic          i_done;
  logic          d_done;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, memory_data, memory_data_valid,
    output mem_en, memory_address, i_grant, d_grant, i_data_valid,
           d_data_valid, fill_data, fill_word, i_done, d_done
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, memory_data, memory_data_valid,
    input  mem_en, memory_address, i_grant, d_grant, i_data_valid,
           d_data_valid, fill_data, fill_word, i_done, d_done
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Shares the pipelined memory read port between the I-cache and D-cache fill
// FSMs. A granted fill issues all block word addresses back to back, then
// steers the in-order returning words to the owner and pulses done on the last.
module mem_fill_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input logic            clk,
  input logic            rst,
  mem_fill_arbiter_if.slave bus
);
  localparam int CW = $clog2(WORDS);
  localparam int BW = 16 - CW - 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);
  // With zero memory latency the final word lands during the last issue cycle.
  localparam bit EARLY_DONE = (MEM_LAT == 0);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        state, state_nx;
  logic          owner, owner_nx;
  logic          last, last_nx;
  logic [BW-1:0] base, base_nx;
  logic [CW-1:0] iss_cnt, iss_cnt_nx;
  logic [CW-1:0] ret_cnt, ret_cnt_nx;
  logic          active;
  logic          take_word;
  logic          fill_end;
  logic          pick_d;

  // State and fill bookkeeping registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b0;
      base    <= '0;
      iss_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      last    <= last_nx;
      base    <= base_nx;
      iss_cnt <= iss_cnt_nx;
      ret_cnt <= ret_cnt_nx;
    end
  end

  // Next-state logic: round-robin grant in IDLE, address issue, in-order return counting.
  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    last_nx    = last;
    base_nx    = base;
    iss_cnt_nx = iss_cnt;
    ret_cnt_nx = ret_cnt;
    active     = (state != IDLE);
    take_word  = active && bus.memory_data_valid;
    fill_end   = take_word && (ret_cnt == LAST_WORD) && ((state == DRAIN) || EARLY_DONE);
    pick_d     = bus.d_req && (!bus.i_req || !last);

    case (state)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          owner_nx   = pick_d;
          base_nx    = pick_d ? bus.d_addr[15:16-BW] : bus.i_addr[15:16-BW];
          iss_cnt_nx = '0;
          ret_cnt_nx = '0;
          state_nx   = ISSUE;
        end
      end
      ISSUE: begin
        iss_cnt_nx = iss_cnt + 1'b1;
        if (iss_cnt == LAST_WORD) state_nx = DRAIN;
      end
      DRAIN: begin
        state_nx = DRAIN;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (take_word) ret_cnt_nx = ret_cnt + 1'b1;

    if (fill_end) begin
      state_nx = IDLE;
      last_nx  = owner;
    end
  end

  // Outputs depend only on registered state and memory returns, never on the requests.
  assign bus.mem_en         = (state == ISSUE);
  assign bus.memory_address = (state == ISSUE) ? {base, iss_cnt, 1'b0} : 16'h0000;
  assign bus.i_grant        = active && !owner;
  assign bus.d_grant        = active && owner;
  assign bus.i_data_valid   = take_word && !owner;
  assign bus.d_data_valid   = take_word && owner;
  assign bus.fill_data      = bus.memory_data;
  assign bus.fill_word      = active ? ret_cnt : '0;
  assign bus.i_done         = fill_end && !owner;
  assign bus.d_done         = fill_end && owner;
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Self-checking bench for mem_fill_arbiter: a fixed-latency memory model, a
// transaction-level reference of the arbitration rules, a table of scenarios
// and hand-written corner sequences, then randomized traffic.
module tb_mem_fill_arbiter;
  localparam int MEM_LAT = 4;
  localparam int WORDS   = 8;

  logic clk;
  logic rst;

  mem_fill_arbiter_if #(.WORDS(WORDS)) bus ();

  mem_fill_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit check_en = 0;

  // Requester and reset stimulus, applied each cycle by tick().
  logic        i_want = 0, d_want = 0, rst_v = 1, spur = 0, rearm = 0;
  logic [15:0] i_addr_v = 0, d_addr_v = 0;

  // Memory model: returns pending reads in order, MEM_LAT cycles after issue.
  int          due_q[$];
  logic [15:0] dat_q[$];

  // Reference model of the arbiter at fill-transaction level.
  bit          m_active = 0;
  bit          m_owner = 0;
  bit          m_last = 0;
  int          m_start = 0;
  int          m_ret = 0;
  logic [15:0] m_base = 0;

  // Observations of DUT behaviour for scenario-level checks.
  int   grant_q[$];
  int   grant_cyc_q[$];
  int   addr0_q[$];
  int   done_cyc_q[$];
  int   dv_cnt = 0;
  logic prev_ig = 0, prev_dg = 0, prev_men = 0;

  typedef struct {
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic [15:0] da;
    int          n_fills;
    int          first;
    int          a0_first;
    int          done0;
    int          second;
    int          a0_second;
    int          done1;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [15:0] pat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  function automatic int q_at(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_obs();
    grant_q.delete();
    grant_cyc_q.delete();
    addr0_q.delete();
    done_cyc_q.delete();
    dv_cnt = 0;
  endtask

  // One clock cycle: drive inputs after the edge, check and observe at negedge.
  task automatic tick();
    logic        mv, ir, dr, e_ig, e_dg, e_men, e_idv, e_ddv, e_idone, e_ddone;
    logic [15:0] md, ia, da, e_addr;
    logic [2:0]  e_fw;
    int          off;
    @(posedge clk);
    #1;
    cyc++;
    ir = i_want; dr = d_want; ia = i_addr_v; da = d_addr_v;
    bus.i_req  = ir;
    bus.d_req  = dr;
    bus.i_addr = ia;
    bus.d_addr = da;
    rst        = rst_v;
    mv = 1'b0;
    md = 16'($urandom);
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      mv = 1'b1;
      md = dat_q[0];
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end else if (spur) begin
      mv = 1'b1;
    end
    bus.memory_data_valid = mv;
    bus.memory_data       = md;
    @(negedge clk);

    off     = cyc - m_start;
    e_ig    = m_active && !m_owner;
    e_dg    = m_active && m_owner;
    e_men   = m_active && (off < WORDS);
    e_addr  = e_men ? m_base + 16'(2 * off) : 16'h0000;
    e_idv   = m_active && !m_owner && mv;
    e_ddv   = m_active && m_owner && mv;
    e_fw    = m_active ? 3'(m_ret) : 3'd0;
    e_idone = e_idv && (m_ret == WORDS - 1);
    e_ddone = e_ddv && (m_ret == WORDS - 1);

    if (check_en) begin
      check_output("i_grant", bus.i_grant, e_ig);
      check_output("d_grant", bus.d_grant, e_dg);
      check_output("mem_en", bus.mem_en, e_men);
      check_output("memory_address", bus.memory_address, e_addr);
      check_output("i_data_valid", bus.i_data_valid, e_idv);
      check_output("d_data_valid", bus.d_data_valid, e_ddv);
      check_output("fill_word", bus.fill_word, e_fw);
      check_output("i_done", bus.i_done, e_idone);
      check_output("d_done", bus.d_done, e_ddone);
      if (e_idv || e_ddv)
        check_output("fill_data", bus.fill_data, pat(m_base + 16'(2 * m_ret)));
    end

    if (bus.i_grant === 1'b1 && prev_ig !== 1'b1) begin grant_q.push_back(0); grant_cyc_q.push_back(cyc); end
    if (bus.d_grant === 1'b1 && prev_dg !== 1'b1) begin grant_q.push_back(1); grant_cyc_q.push_back(cyc); end
    if (bus.mem_en === 1'b1 && prev_men !== 1'b1) addr0_q.push_back(int'(bus.memory_address));
    if (bus.i_done === 1'b1 || bus.d_done === 1'b1) done_cyc_q.push_back(cyc);
    if (bus.i_data_valid === 1'b1 || bus.d_data_valid === 1'b1) dv_cnt++;
    prev_ig = bus.i_grant; prev_dg = bus.d_grant; prev_men = bus.mem_en;

    if (bus.mem_en === 1'b1) begin
      due_q.push_back(cyc + MEM_LAT);
      dat_q.push_back(pat(bus.memory_address));
    end

    if (rst_v) begin
      m_active = 0;
      m_last   = 0;
    end else if (m_active) begin
      if (mv) begin
        if (m_ret == WORDS - 1) begin
          m_active = 0;
          m_last   = m_owner;
          if (!rearm) begin
            if (m_owner) d_want = 0;
            else i_want = 0;
          end
        end else begin
          m_ret++;
        end
      end
    end else if (ir || dr) begin
      m_owner  = dr && (!ir || !m_last);
      m_base   = (m_owner ? da : ia) & 16'hFFF0;
      m_start  = cyc + 1;
      m_ret    = 0;
      m_active = 1;
    end
  endtask

  task automatic apply_stimulus(input logic ir, input logic [15:0] ia,
                                input logic dr, input logic [15:0] da);
    i_want = ir; i_addr_v = ia;
    d_want = dr; d_addr_v = da;
  endtask

  // Run until the model is idle with nothing pending; overrunning the bound is a failure.
  task automatic wait_idle(input int bound);
    int n = 0;
    while ((m_active || i_want || d_want) && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (m_active || i_want || d_want) begin
      errors++;
      $display("[TB] FAIL timeout cyc=%0d actual=busy required=idle", cyc);
      i_want = 0; d_want = 0;
    end
  endtask

  initial begin
    int s;
    int n;
    clk = 0;
    rst = 1;
    bus.i_req = 0; bus.d_req = 0; bus.i_addr = 0; bus.d_addr = 0;
    bus.memory_data = 0; bus.memory_data_valid = 0;

    vecs[0] = '{1'b1, 16'h0040, 1'b1, 16'h8000, 2, 1, 16'h8000, 12, 0, 16'h0040, 25};
    vecs[1] = '{1'b1, 16'h1236, 1'b0, 16'h0000, 1, 0, 16'h1230, 12, -1, -1, -1};
    vecs[2] = '{1'b1, 16'hABCD, 1'b1, 16'h5557, 2, 1, 16'h5550, 12, 0, 16'hABC0, 25};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 16'hFFFF, 1, 1, 16'hFFF0, 12, -1, -1, -1};
    vecs[4] = '{1'b1, 16'h0008, 1'b1, 16'h7772, 2, 0, 16'h0000, 12, 1, 16'h7770, 25};

    $display("[TB] reset");
    rst_v = 1;
    tick(); tick();
    rst_v = 0;
    check_en = 1;
    tick();
    check_output("rst_grant", {bus.i_grant, bus.d_grant}, 2'b00);
    check_output("rst_addr", bus.memory_address, 16'h0000);

    $display("[TB] scenario table");
    for (int k = 0; k < 5; k++) begin
      clear_obs();
      s = cyc + 1;
      apply_stimulus(vecs[k].ir, vecs[k].ia, vecs[k].dr, vecs[k].da);
      wait_idle(80);
      tick(); tick();
      check_output($sformatf("tbl%0d_nfills", k), grant_q.size(), vecs[k].n_fills);
      check_output($sformatf("tbl%0d_first", k), q_at(grant_q, 0), vecs[k].first);
      check_output($sformatf("tbl%0d_addr0", k), q_at(addr0_q, 0), vecs[k].a0_first);
      check_output($sformatf("tbl%0d_done0", k), q_at(done_cyc_q, 0) - s, vecs[k].done0);
      check_output($sformatf("tbl%0d_grant0", k), q_at(grant_cyc_q, 0) - s, 1);
      if (vecs[k].n_fills == 2) begin
        check_output($sformatf("tbl%0d_second", k), q_at(grant_q, 1), vecs[k].second);
        check_output($sformatf("tbl%0d_addr1", k), q_at(addr0_q, 1), vecs[k].a0_second);
        check_output($sformatf("tbl%0d_done1", k), q_at(done_cyc_q, 1) - s, vecs[k].done1);
      end
    end

    $display("[TB] reset mid-fill");
    clear_obs();
    apply_stimulus(1'b1, 16'h2468, 1'b0, 16'h0000);
    tick();
    i_want = 0;
    tick(); tick(); tick();
    rst_v = 1;
    tick();
    rst_v = 0;
    dv_cnt = 0;
    done_cyc_q.delete();
    tick();
    check_output("midrst_outputs", {bus.mem_en, bus.i_grant, bus.d_grant, bus.memory_address}, 19'h0);
    for (int k = 0; k < 7; k++) tick();
    check_output("midrst_stale_dv", dv_cnt, 0);
    check_output("midrst_stale_done", done_cyc_q.size(), 0);

    $display("[TB] idle valid and one-cycle request");
    clear_obs();
    spur = 1; tick(); spur = 0; tick();
    check_output("spur_dv", dv_cnt, 0);
    s = cyc + 1;
    apply_stimulus(1'b1, 16'h0F0E, 1'b0, 16'h0000);
    tick();
    i_want = 0;
    wait_idle(40);
    check_output("pulse_dv_words", dv_cnt, WORDS);
    check_output("pulse_done", q_at(done_cyc_q, 0) - s, 12);

    $display("[TB] round robin");
    clear_obs();
    rearm = 1;
    apply_stimulus(1'b1, 16'h3000, 1'b1, 16'hC000);
    n = 0;
    while (grant_q.size() < 3 && n < 100) begin tick(); n++; end
    rearm = 0;
    i_want = 0;
    wait_idle(40);
    check_output("rr_count", grant_q.size(), 3);
    check_output("rr_g0", q_at(grant_q, 0), 1);
    check_output("rr_g1", q_at(grant_q, 1), 0);
    check_output("rr_g2", q_at(grant_q, 2), 1);

    $display("[TB] late D request during I drain");
    clear_obs();
    s = cyc + 1;
    apply_stimulus(1'b1, 16'h4442, 1'b0, 16'h0000);
    for (int k = 0; k < 10; k++) tick();
    d_want = 1; d_addr_v = 16'h9998;
    wait_idle(60);
    check_output("late_order0", q_at(grant_q, 0), 0);
    check_output("late_order1", q_at(grant_q, 1), 1);
    check_output("late_i_done", q_at(done_cyc_q, 0) - s, 12);
    check_output("late_d_grant", q_at(grant_cyc_q, 1) - q_at(done_cyc_q, 0), 2);

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      if (!i_want && $urandom_range(0, 3) == 0) begin i_want = 1; i_addr_v = 16'($urandom); end
      if (!d_want && $urandom_range(0, 3) == 0) begin d_want = 1; d_addr_v = 16'($urandom); end
      spur = !m_active && (due_q.size() == 0) && ($urandom_range(0, 4) == 0);
      tick();
      spur = 0;
    end
    wait_idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
